// File: rtl/wbxbc_arb_pkg.sv
// Shared helpers for the pipelined Wishbone arbiter: sizing, grant sanity
// check and the round-robin pick used by the selector.
package wbxbc_arb_pkg;
  localparam int MAX_ITR = 16;
  localparam int MAX_IDX_W = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic is_onehot0(input logic [MAX_ITR-1:0] v);
    return (v & (v - 1'b1)) == '0;
  endfunction

  // First requester strictly after 'last', wrapping within n initiators.
  function automatic logic [MAX_ITR-1:0] rr_pick(input logic [MAX_ITR-1:0] req,
                                                 input int n, input int last);
    logic [MAX_ITR-1:0] g;
    logic found;
    int idx;
    logic [MAX_IDX_W-1:0] i4;
    g = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_ITR; k++) begin
      idx = (last + k) % n;
      i4 = idx[MAX_IDX_W-1:0];
      if (k <= n && !found && req[i4]) begin
        g[i4] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/wbxbc_rr_sel.sv
// Combinational round-robin selector: next one-hot grant and its index.
module wbxbc_rr_sel
  import wbxbc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [LW-1:0] gnt_idx
);
  logic [MAX_ITR-1:0] pick;

  always_comb begin
    pick    = rr_pick(MAX_ITR'(req), N, int'(last));
    gnt     = pick[N-1:0];
    gnt_idx = '0;
    for (int i = 0; i < N; i++)
      if (pick[i]) gnt_idx = LW'(i);
  end
endmodule

// File: rtl/wbxbc_pipe_arb.sv
// Round-robin arbiter sharing one pipelined Wishbone target among ITR_CNT
// initiators, with a cap on accepted-but-unterminated requests.
module wbxbc_pipe_arb
  import wbxbc_arb_pkg::*;
#(
  parameter int ITR_CNT   = 4,
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 2,
  parameter int MAX_OUT   = 4
) (
  input  logic                           clk_i,
  input  logic                           sync_rst_i,
  input  logic [ITR_CNT-1:0]             itr_cyc_i,
  input  logic [ITR_CNT-1:0]             itr_stb_i,
  input  logic [ITR_CNT-1:0]             itr_we_i,
  input  logic [ITR_CNT-1:0]             itr_lock_i,
  input  logic [ITR_CNT*SEL_WIDTH-1:0]   itr_sel_i,
  input  logic [ITR_CNT*ADR_WIDTH-1:0]   itr_adr_i,
  input  logic [ITR_CNT*DAT_WIDTH-1:0]   itr_dat_i,
  output logic [ITR_CNT-1:0]             itr_ack_o,
  output logic [ITR_CNT-1:0]             itr_err_o,
  output logic [ITR_CNT-1:0]             itr_rty_o,
  output logic [ITR_CNT-1:0]             itr_stall_o,
  output logic [DAT_WIDTH-1:0]           itr_dat_o,
  output logic                           tgt_cyc_o,
  output logic                           tgt_stb_o,
  output logic                           tgt_we_o,
  output logic                           tgt_lock_o,
  output logic [SEL_WIDTH-1:0]           tgt_sel_o,
  output logic [ADR_WIDTH-1:0]           tgt_adr_o,
  output logic [DAT_WIDTH-1:0]           tgt_dat_o,
  input  logic                           tgt_ack_i,
  input  logic                           tgt_err_i,
  input  logic                           tgt_rty_i,
  input  logic                           tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]           tgt_dat_i
);
  localparam int LW = clog2(ITR_CNT);
  localparam int CW = clog2(MAX_OUT + 1);

  logic [ITR_CNT-1:0] gnt_reg, nxt_gnt;
  logic [LW-1:0]      last_reg, nxt_idx;
  logic [CW-1:0]      out_cnt;

  logic owned, cap, has_out, accept, term, release_own;
  logic own_cyc, own_stb, own_we, own_lock;
  logic [SEL_WIDTH-1:0] own_sel;
  logic [ADR_WIDTH-1:0] own_adr;
  logic [DAT_WIDTH-1:0] own_dat;

  wbxbc_rr_sel #(.N(ITR_CNT), .LW(LW)) u_sel (
    .req     (itr_cyc_i),
    .last    (last_reg),
    .gnt     (nxt_gnt),
    .gnt_idx (nxt_idx)
  );

  // AND-OR mux on the one-hot grant; everything reads zero while idle.
  always_comb begin
    own_cyc  = |(gnt_reg & itr_cyc_i);
    own_stb  = |(gnt_reg & itr_stb_i);
    own_we   = |(gnt_reg & itr_we_i);
    own_lock = |(gnt_reg & itr_lock_i);
    own_sel  = '0;
    own_adr  = '0;
    own_dat  = '0;
    for (int i = 0; i < ITR_CNT; i++) begin
      if (gnt_reg[i]) begin
        own_sel = own_sel | itr_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
        own_adr = own_adr | itr_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
        own_dat = own_dat | itr_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign owned       = |gnt_reg;
  assign cap         = (out_cnt == CW'(MAX_OUT));
  assign has_out     = (out_cnt != '0);
  assign release_own = owned & ~own_cyc & ~own_lock;

  assign tgt_cyc_o  = own_cyc;
  assign tgt_stb_o  = own_stb & ~cap;
  assign tgt_we_o   = own_we;
  assign tgt_lock_o = own_lock;
  assign tgt_sel_o  = own_sel;
  assign tgt_adr_o  = own_adr;
  assign tgt_dat_o  = own_dat;

  assign accept = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
  assign term   = (tgt_ack_i | tgt_err_i | tgt_rty_i) & has_out;

  // Terminations with nothing outstanding are strays and go nowhere.
  assign itr_ack_o   = gnt_reg & {ITR_CNT{tgt_ack_i & has_out}};
  assign itr_err_o   = gnt_reg & {ITR_CNT{tgt_err_i & has_out}};
  assign itr_rty_o   = gnt_reg & {ITR_CNT{tgt_rty_i & has_out}};
  assign itr_stall_o = ~gnt_reg | {ITR_CNT{tgt_stall_i | cap}};
  assign itr_dat_o   = tgt_dat_i;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      gnt_reg  <= '0;
      last_reg <= LW'(ITR_CNT - 1);
      out_cnt  <= '0;
    end else if (!owned) begin
      if (|itr_cyc_i) begin
        gnt_reg  <= nxt_gnt;
        last_reg <= nxt_idx;
      end
    end else if (release_own) begin
      gnt_reg <= '0;
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(accept) - CW'(term);
    end
  end

  always_ff @(posedge clk_i)
    if (!sync_rst_i) assert (is_onehot0(MAX_ITR'(gnt_reg)));
endmodule
